sort_mem_arbiter: RTL
=====================

// Module: sort_mem_arbiter
// PURPOSE
//   Shares the single-port array RAM of the quick-sort engine between two requesters:
//   - the host loader/unloader (single reads and writes);
//   - the sort datapath (single reads and writes, plus atomic element swaps).
//   Round-robin arbitration between the two. A swap runs as one uninterruptible
//   4-cycle RAM sequence, so the host never sees a half-swapped array.
// PARAMETERS
//   WORD_SIZE  16  data width of one array element
//   ADDR_W     5   RAM address width (32 elements)
// PORTS
//   clk          in   1          system clock, all logic on rising edge
//   reset_n      in   1          synchronous reset, active low
//   host_req     in   1          host access request, held until host_gnt
//   host_we      in   1          1=write, 0=read
//   host_addr    in   ADDR_W     host address
//   host_wdata   in   WORD_SIZE  host write data
//   host_gnt     out  1          1-cycle pulse: host command issued to RAM
//   host_rvalid  out  1          1-cycle pulse: host_rdata valid
//   host_rdata   out  WORD_SIZE  read data (= mem_rdata)
//   eng_req      in   1          engine request, held until eng_gnt
//   eng_we       in   1          1=write, 0=read (ignored when eng_swap=1)
//   eng_swap     in   1          1=swap mem[eng_addr1] and mem[eng_addr2]
//   eng_addr1    in   ADDR_W     single-access address / swap address 1
//   eng_addr2    in   ADDR_W     swap address 2
//   eng_wdata    in   WORD_SIZE  engine write data
//   eng_gnt      out  1          1-cycle pulse: engine command accepted
//   eng_rvalid   out  1          1-cycle pulse: eng_rdata valid
//   eng_rdata    out  WORD_SIZE  read data (= mem_rdata)
//   eng_swap_done out 1          1-cycle pulse: swap fully written
//   mem_en       out  1          RAM access enable
//   mem_we       out  1          RAM write enable
//   mem_addr     out  ADDR_W     RAM address
//   mem_wdata    out  WORD_SIZE  RAM write data
//   mem_rdata    in   WORD_SIZE  RAM read data, valid 1 cycle after read mem_en
// BEHAVIOUR
//   - FSM states: IDLE, ACCESS, SW_RD1, SW_RD2, SW_WR1, SW_WR2.
//   - mem_* outputs are combinational decodes of the state and the latched command.
//   - Arbitration and state transitions:
//     - IDLE samples both req inputs; the winner's addr/we/wdata/swap/owner are latched at the edge.
//     - Winner goes to ACCESS (single access) or SW_RD1 (engine swap).
//     - Tie: winner is the requester NOT granted last. last_gnt resets to host, so the engine wins the first tie.
//     - ACCESS: mem_en=1, mem_we/addr/wdata from latch; gnt pulse of owner high; next state IDLE.
//     - Read latency: the cycle after ACCESS, owner rvalid=1 and rdata=mem_rdata.
//       That is 2 cycles after the sampled request; max 1 access per 2 cycles.
//     - SW_RD1: read addr1, eng_gnt=1.
//     - SW_RD2: read addr2; latch d1=mem_rdata.
//     - SW_WR1: write addr1 <= mem_rdata (d2).
//     - SW_WR2: write addr2 <= d1; eng_swap_done=1 the following cycle; next state IDLE.
//   - Requests are sampled only in IDLE. Any req asserted during a swap or ACCESS waits, with no grant and no loss.
//   - Requester handshake: keep req/command stable until its gnt pulse. req still high in the cycle after gnt = new request.
//   - eng_addr1==eng_addr2 swap: full 4-cycle sequence runs; element value unchanged.
//   - Reset values (reset_n=0 at an edge): state=IDLE, last_gnt=host, d1=0.
//     - All gnt/rvalid/swap_done outputs 0; mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
//   - Reset mid-operation aborts immediately. No pending gnt, rvalid or swap_done is emitted.
//     An aborted swap may leave the two elements partially written; this is allowed.
//   - host_rdata/eng_rdata are not held; only meaningful while the matching rvalid=1.
// TESTING
//   - Reset: reset_n=0 for 2 clk with random inputs -> all outputs 0, mem_en=0.
//   - Host write/read: write addr 3 = 0x00AA, then read addr 3.
//     -> host_gnt pulses; host_rvalid 2 cycles after read req sampled; host_rdata=0x00AA.
//   - Swap: mem[2]=0x0011, mem[7]=0x0099; engine swap 2<->7.
//     -> mem_en high 4 consecutive cycles (R,R,W,W); eng_swap_done next cycle; mem[2]=0x0099, mem[7]=0x0011.
//   - Contention: host and engine reads continuously requested after reset.
//     -> grants alternate eng,host,eng,host; each rvalid returns its own requester's address data.
//   - Host during swap: host_req raised in SW_RD2 -> no host_gnt before SW_WR2 completes; host read then sees swapped data.
//   - Reset mid-swap: reset_n=0 in SW_WR1 -> next cycle mem_en=0, eng_swap_done never pulses, then new host read works.

Source files
------------

// File: rtl/sort_mem_arbiter.sv
// Round-robin arbiter sharing the sort RAM between host and engine, with atomic 4-cycle swaps.
// Latency: grant 1 cycle after a request is sampled in IDLE, read data 1 cycle after grant; swap_done 4 cycles after grant.
// Backpressure: a requester holds req until its gnt pulse; requests arriving while busy wait in place.
module sort_mem_arbiter #(
    parameter int WORD_SIZE = 16,
    parameter int ADDR_W    = 5
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 host_req,
    input  logic                 host_we,
    input  logic [ADDR_W-1:0]    host_addr,
    input  logic [WORD_SIZE-1:0] host_wdata,
    output logic                 host_gnt,
    output logic                 host_rvalid,
    output logic [WORD_SIZE-1:0] host_rdata,
    input  logic                 eng_req,
    input  logic                 eng_we,
    input  logic                 eng_swap,
    input  logic [ADDR_W-1:0]    eng_addr1,
    input  logic [ADDR_W-1:0]    eng_addr2,
    input  logic [WORD_SIZE-1:0] eng_wdata,
    output logic                 eng_gnt,
    output logic                 eng_rvalid,
    output logic [WORD_SIZE-1:0] eng_rdata,
    output logic                 eng_swap_done,
    output logic                 mem_en,
    output logic                 mem_we,
    output logic [ADDR_W-1:0]    mem_addr,
    output logic [WORD_SIZE-1:0] mem_wdata,
    input  logic [WORD_SIZE-1:0] mem_rdata
);

    typedef enum logic [2:0] {IDLE, ACCESS, SW_RD1, SW_RD2, SW_WR1, SW_WR2} state_t;

    state_t                 state;
    logic                   owner_eng;
    logic                   last_eng;
    logic                   cmd_we;
    logic [ADDR_W-1:0]      cmd_addr1;
    logic [ADDR_W-1:0]      cmd_addr2;
    logic [WORD_SIZE-1:0]   cmd_wdata;
    logic [WORD_SIZE-1:0]   d1;
    logic                   host_rv_q;
    logic                   eng_rv_q;
    logic                   swap_done_q;
    logic                   eng_wins;

    // Engine takes the slot when alone, or on a tie when the host was granted last.
    assign eng_wins = eng_req && (!host_req || !last_eng);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= IDLE;
            owner_eng   <= 1'b0;
            last_eng    <= 1'b0;
            cmd_we      <= 1'b0;
            cmd_addr1   <= '0;
            cmd_addr2   <= '0;
            cmd_wdata   <= '0;
            d1          <= '0;
            host_rv_q   <= 1'b0;
            eng_rv_q    <= 1'b0;
            swap_done_q <= 1'b0;
        end else begin
            host_rv_q   <= 1'b0;
            eng_rv_q    <= 1'b0;
            swap_done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (eng_wins) begin
                        owner_eng <= 1'b1;
                        last_eng  <= 1'b1;
                        cmd_we    <= eng_we & ~eng_swap;
                        cmd_addr1 <= eng_addr1;
                        cmd_addr2 <= eng_addr2;
                        cmd_wdata <= eng_wdata;
                        state     <= eng_swap ? SW_RD1 : ACCESS;
                    end else if (host_req) begin
                        owner_eng <= 1'b0;
                        last_eng  <= 1'b0;
                        cmd_we    <= host_we;
                        cmd_addr1 <= host_addr;
                        cmd_addr2 <= '0;
                        cmd_wdata <= host_wdata;
                        state     <= ACCESS;
                    end
                end
                ACCESS: begin
                    host_rv_q <= !cmd_we && !owner_eng;
                    eng_rv_q  <= !cmd_we && owner_eng;
                    state     <= IDLE;
                end
                SW_RD1: state <= SW_RD2;
                SW_RD2: begin
                    d1    <= mem_rdata;
                    state <= SW_WR1;
                end
                SW_WR1: state <= SW_WR2;
                SW_WR2: begin
                    swap_done_q <= 1'b1;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // SW_WR1 writes the second element straight from the RAM read port (addr2 read in SW_RD2).
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state)
            ACCESS: begin
                mem_en    = 1'b1;
                mem_we    = cmd_we;
                mem_addr  = cmd_addr1;
                mem_wdata = cmd_we ? cmd_wdata : '0;
            end
            SW_RD1: begin
                mem_en   = 1'b1;
                mem_addr = cmd_addr1;
            end
            SW_RD2: begin
                mem_en   = 1'b1;
                mem_addr = cmd_addr2;
            end
            SW_WR1: begin
                mem_en    = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = cmd_addr1;
                mem_wdata = mem_rdata;
            end
            SW_WR2: begin
                mem_en    = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = cmd_addr2;
                mem_wdata = d1;
            end
            default: ;
        endcase
    end

    assign host_gnt      = (state == ACCESS) && !owner_eng;
    assign eng_gnt       = ((state == ACCESS) && owner_eng) || (state == SW_RD1);
    assign host_rvalid   = host_rv_q;
    assign eng_rvalid    = eng_rv_q;
    assign eng_swap_done = swap_done_q;
    assign host_rdata    = mem_rdata;
    assign eng_rdata     = mem_rdata;

endmodule
